// File: rtl/ram_port_arbiter_if.sv
// Shared RAM command bus between the two masters, the arbiter and RAMControl.
// The slave modport is the arbiter's view; master is the view of the masters and RAMControl.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              ram_ready;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_instruction;
  logic              ram_latch;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              timeout_err;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    input  ram_ready, ram_rdata,
    output ram_instruction, ram_latch, ram_addr, ram_wdata, timeout_err
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    output ram_ready, ram_rdata,
    input  ram_instruction, ram_latch, ram_addr, ram_wdata, timeout_err
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter serialising Network (m0) and DNAInitializer (m1) word
// requests onto RAMControl, with a watchdog bounding every transaction.
module ram_port_arbiter #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  ram_port_arbiter_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } state_t;

  state_t            state, nextState;
  logic              rrLast;
  logic              grant;        // 0 = m0, 1 = m1
  logic              grantNext;
  logic              doGrant;
  logic              doComplete;
  logic              doAbort;
  logic              inWait;
  logic              wdogExpired;
  logic [WD_W-1:0]   wdog;

  logic              ramLatch;
  logic              ramInstr;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWdata;
  logic              m0Ack, m1Ack;
  logic [DATA_W-1:0] m0Rdata, m1Rdata;
  logic              timeoutErr;

  assign inWait      = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign wdogExpired = (wdog == WD_W'(TIMEOUT_CYCLES));

  always_comb begin
    nextState  = state;
    grantNext  = grant;
    doGrant    = 1'b0;
    doComplete = 1'b0;
    doAbort    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ram_ready && (bus.m0_req || bus.m1_req)) begin
          doGrant   = 1'b1;
          grantNext = (bus.m0_req && bus.m1_req) ? ~rrLast : bus.m1_req;
          nextState = ISSUE;
        end
      end
      ISSUE: nextState = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wdogExpired) begin
          doAbort   = 1'b1;
          nextState = DONE;
        end else if (!bus.ram_ready) begin
          nextState = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A real completion wins over a watchdog expiring on the same edge.
        if (bus.ram_ready) begin
          doComplete = 1'b1;
          nextState  = DONE;
        end else if (wdogExpired) begin
          doAbort   = 1'b1;
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rrLast     <= 1'b1;
      grant      <= 1'b0;
      wdog       <= '0;
      ramLatch   <= 1'b0;
      ramInstr   <= 1'b0;
      ramAddr    <= '0;
      ramWdata   <= '0;
      m0Ack      <= 1'b0;
      m1Ack      <= 1'b0;
      m0Rdata    <= '0;
      m1Rdata    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      state    <= nextState;
      ramLatch <= (nextState == ISSUE);
      // Acks are raised on entry to DONE so the requester sees them while DONE
      // returns to IDLE, keeping IDLE from sampling a stale req.
      m0Ack    <= (nextState == DONE) && (state != DONE) && !grant;
      m1Ack    <= (nextState == DONE) && (state != DONE) && grant;

      if (inWait && (nextState != DONE)) wdog <= wdog + 1'b1;
      else                               wdog <= '0;

      if (doGrant) begin
        grant <= grantNext;
        if (bus.m0_req && bus.m1_req) rrLast <= grantNext;
        ramAddr  <= grantNext ? bus.m1_addr  : bus.m0_addr;
        ramWdata <= grantNext ? bus.m1_wdata : bus.m0_wdata;
        ramInstr <= grantNext ? bus.m1_we    : bus.m0_we;
      end

      if (doComplete && !ramInstr) begin
        if (grant) m1Rdata <= bus.ram_rdata;
        else       m0Rdata <= bus.ram_rdata;
      end

      if (doAbort) begin
        timeoutErr <= 1'b1;
        if (!ramInstr) begin
          if (grant) m1Rdata <= '0;
          else       m0Rdata <= '0;
        end
      end
    end
  end

  assign bus.ram_latch       = ramLatch;
  assign bus.ram_instruction = ramInstr;
  assign bus.ram_addr        = ramAddr;
  assign bus.ram_wdata       = ramWdata;
  assign bus.m0_ack          = m0Ack;
  assign bus.m1_ack          = m1Ack;
  assign bus.m0_rdata        = m0Rdata;
  assign bus.m1_rdata        = m1Rdata;
  assign bus.timeout_err     = timeoutErr;

endmodule
